// File: rtl/sa_ctrl_pkg.sv
// Shared types and helpers for the output-stationary systolic array sequencer.
package sa_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      COMPUTE,
      FLUSH,
      DRAIN,
      DONE
   } sa_seq_state_t;

   // Cycles of zero operands needed to push the last real operands through skew and FMA latency.
   function automatic int flush_cycles(input int rows, input int cols, input int fma_lat);
      return rows + cols - 2 + fma_lat;
   endfunction

endpackage

// File: rtl/sa_seq_counter.sv
// Up-counter with synchronous clear-to-zero load, count enable and terminal-count flag.
module sa_seq_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == last);

endmodule

// File: rtl/sa_os_sequencer.sv
// Tile sequencer for an output-stationary systolic array: clear, compute, flush, drain.
module sa_os_sequencer
   import sa_ctrl_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int FMA_LAT = 3,
   parameter int K_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [K_W-1:0]          k_len,
   output logic                    busy,
   output logic                    done,
   input  logic                    feed_valid,
   output logic                    feed_ready,
   output logic                    zero_feed,
   output logic                    pe_reg_clear,
   output logic                    pe_pipe_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(ROWS)-1:0] drain_row
);

   localparam int FLUSH_CYC = flush_cycles(ROWS, COLS, FMA_LAT);
   localparam int FW        = $clog2(FLUSH_CYC + 1);
   localparam int RW        = $clog2(ROWS);

   sa_seq_state_t  state;
   sa_seq_state_t  state_nxt;
   logic [K_W-1:0] k_cap;
   logic [K_W-1:0] beat_cnt;
   logic [FW-1:0]  flush_cnt;
   logic [RW-1:0]  row_cnt;
   logic           beat_tc;
   logic           flush_tc;
   logic           row_tc;
   logic           beat;
   logic           row_adv;
   logic           unused_cnts;

   assign beat    = (state == COMPUTE) && feed_valid;
   assign row_adv = (state == DRAIN) && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // k_len is only meaningful alongside an accepted start; it needs no reset.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && start) begin
         k_cap <= k_len;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CLEAR;
         CLEAR:   state_nxt = (k_cap == '0) ? FLUSH : COMPUTE;
         COMPUTE: if (beat && beat_tc) state_nxt = FLUSH;
         FLUSH:   if (flush_tc) state_nxt = DRAIN;
         DRAIN:   if (row_adv && row_tc) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Each counter is held at zero outside the state that uses it.
   sa_seq_counter #(.W(K_W)) u_beat (
      .clk   (clk),
      .rst   (rst),
      .load  (state != COMPUTE),
      .en    (beat),
      .last  (k_cap - K_W'(1)),
      .count (beat_cnt),
      .tc    (beat_tc)
   );

   sa_seq_counter #(.W(FW)) u_flush (
      .clk   (clk),
      .rst   (rst),
      .load  (state != FLUSH),
      .en    (1'b1),
      .last  (FW'(FLUSH_CYC - 1)),
      .count (flush_cnt),
      .tc    (flush_tc)
   );

   sa_seq_counter #(.W(RW)) u_row (
      .clk   (clk),
      .rst   (rst),
      .load  (state != DRAIN),
      .en    (row_adv),
      .last  (RW'(ROWS - 1)),
      .count (row_cnt),
      .tc    (row_tc)
   );

   assign unused_cnts = ^{beat_cnt, flush_cnt};

   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign feed_ready   = (state == COMPUTE);
   assign zero_feed    = (state == FLUSH);
   assign pe_reg_clear = (state == CLEAR);
   assign pe_pipe_en   = (state == FLUSH) || beat;
   assign out_valid    = (state == DRAIN);
   assign drain_row    = row_cnt;

endmodule

// File: tb/tb_sa_os_sequencer.sv
// Randomized and directed bench for sa_os_sequencer against a phase/remaining-work model.
module tb_sa_os_sequencer;

   localparam int ROWS    = 4;
   localparam int COLS    = 4;
   localparam int FMA_LAT = 3;
   localparam int K_W     = 16;
   localparam int FLUSH   = ROWS + COLS - 2 + FMA_LAT;
   localparam int RW      = $clog2(ROWS);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [K_W-1:0] k_len = '0;
   logic           busy;
   logic           done;
   logic           feed_valid = 1'b0;
   logic           feed_ready;
   logic           zero_feed;
   logic           pe_reg_clear;
   logic           pe_pipe_en;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [RW-1:0]  drain_row;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 clear, 2 compute, 3 flush, 4 drain, 5 done; m_left = work remaining in phase.
   int m_phase = 0;
   int m_left  = 0;
   int m_k     = 0;

   sa_os_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .FMA_LAT(FMA_LAT), .K_W(K_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .k_len        (k_len),
      .busy         (busy),
      .done         (done),
      .feed_valid   (feed_valid),
      .feed_ready   (feed_ready),
      .zero_feed    (zero_feed),
      .pe_reg_clear (pe_reg_clear),
      .pe_pipe_en   (pe_pipe_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .drain_row    (drain_row)
   );

   always #5 clk = ~clk;

   wire [6+RW:0] obs = {busy, done, feed_ready, zero_feed, pe_reg_clear, pe_pipe_en, out_valid, drain_row};

   function automatic logic [6+RW:0] model_out();
      logic [RW-1:0] row;
      row = (m_phase == 4) ? RW'(ROWS - m_left) : '0;
      return {m_phase != 0, m_phase == 5, m_phase == 2, m_phase == 3, m_phase == 1,
              (m_phase == 3) || (m_phase == 2 && feed_valid), m_phase == 4, row};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (start) begin m_k = int'(k_len); m_phase = 1; end
            1: if (m_k == 0) begin m_phase = 3; m_left = FLUSH; end
               else begin m_phase = 2; m_left = m_k; end
            2: if (feed_valid) begin
                  m_left--;
                  if (m_left == 0) begin m_phase = 3; m_left = FLUSH; end
               end
            3: begin
                  m_left--;
                  if (m_left == 0) begin m_phase = 4; m_left = ROWS; end
               end
            4: if (out_ready) begin
                  m_left--;
                  if (m_left == 0) m_phase = 5;
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // One tile from start (cycle 0) until the model is back in idle; cycles counted from the start cycle.
   task automatic run_tile(input int k, input int fv_lo, input int fv_hi, input int or_lo,
                           input int rst_at, input bit rnd, input bit spur,
                           output int done_cyc, output int ndone);
      int  drain_seen;
      bit  finished;
      drain_seen = 0;
      finished   = 1'b0;
      done_cyc   = -1;
      ndone      = 0;
      for (int c = 0; c < 2000; c++) begin
         if (c > 0 && m_phase == 0) begin
            start = 1'b0;
            rst   = 1'b0;
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
               errors++;
               $display("FAIL idle_after_tile cycle %0d got %b expected %b", c, obs, model_out());
            end
            finished = 1'b1;
            break;
         end
         rst        = (c == rst_at);
         start      = (c == 0) || (spur && m_phase != 0 && (($urandom % 4) == 0 || m_phase == 5));
         k_len      = (c == 0) ? K_W'(k) : K_W'($urandom);
         feed_valid = rnd ? (($urandom % 4) != 0) : !(c >= fv_lo && c <= fv_hi);
         out_ready  = rnd ? (($urandom % 3) != 0) : !(m_phase == 4 && drain_seen < or_lo);
         if (m_phase == 4) drain_seen++;
         @(negedge clk);
         checks++;
         if (obs !== model_out()) begin
            errors++;
            $display("FAIL outputs cycle %0d got %b expected %b", c, obs, model_out());
         end
         if (done === 1'b1) begin
            ndone++;
            done_cyc = c;
         end
         tick();
      end
      if (!finished) begin
         errors++;
         $display("FAIL tile_timeout got busy=%b expected idle within 2000 cycles", busy);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; k_len = 16'd5; feed_valid = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected %b", obs, {(7+RW){1'b0}});
      end
      rst = 1'b0; start = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int d, n;
      run_tile(8, -1, -1, 0, -1, 1'b0, 1'b0, d, n);
      checks++;
      if (d != 23) begin errors++; $display("FAIL basic_done_cycle got %0d expected 23", d); end
      checks++;
      if (n != 1) begin errors++; $display("FAIL basic_done_count got %0d expected 1", n); end
   endtask

   task automatic test_feed_stall();
      int d, n;
      run_tile(8, 4, 6, 0, -1, 1'b0, 1'b0, d, n);
      checks++;
      if (d != 26) begin errors++; $display("FAIL feed_stall_done_cycle got %0d expected 26", d); end
      checks++;
      if (n != 1) begin errors++; $display("FAIL feed_stall_done_count got %0d expected 1", n); end
   endtask

   task automatic test_out_stall();
      int d, n;
      run_tile(8, -1, -1, 2, -1, 1'b0, 1'b0, d, n);
      checks++;
      if (d != 25) begin errors++; $display("FAIL out_stall_done_cycle got %0d expected 25", d); end
      checks++;
      if (n != 1) begin errors++; $display("FAIL out_stall_done_count got %0d expected 1", n); end
   endtask

   task automatic test_k_zero();
      int d, n;
      run_tile(0, -1, -1, 0, -1, 1'b0, 1'b0, d, n);
      checks++;
      if (d != 15) begin errors++; $display("FAIL k_zero_done_cycle got %0d expected 15", d); end
      checks++;
      if (n != 1) begin errors++; $display("FAIL k_zero_done_count got %0d expected 1", n); end
   endtask

   task automatic test_mid_reset();
      int d, n;
      run_tile(8, -1, -1, 0, 12, 1'b0, 1'b0, d, n);
      checks++;
      if (n != 0) begin errors++; $display("FAIL mid_reset_done_count got %0d expected 0", n); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
      run_tile(8, -1, -1, 0, -1, 1'b0, 1'b0, d, n);
      checks++;
      if (d != 23) begin errors++; $display("FAIL restart_done_cycle got %0d expected 23", d); end
   endtask

   task automatic test_ignored_start();
      int d, n;
      run_tile(6, -1, -1, 0, -1, 1'b0, 1'b1, d, n);
      checks++;
      if (d != 6 + 2 + FLUSH + ROWS) begin
         errors++;
         $display("FAIL spur_start_done_cycle got %0d expected %0d", d, 6 + 2 + FLUSH + ROWS);
      end
      checks++;
      if (n != 1) begin errors++; $display("FAIL spur_start_done_count got %0d expected 1", n); end
   endtask

   task automatic test_random();
      int d, n, k;
      for (int t = 0; t < 8; t++) begin
         k = int'($urandom_range(0, 12));
         run_tile(k, -1, -1, 0, -1, 1'b1, 1'b1, d, n);
         checks++;
         if (n != 1) begin
            errors++;
            $display("FAIL random_done_count tile %0d k=%0d got %0d expected 1", t, k, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_feed_stall();
      test_out_stall();
      test_k_zero();
      test_mid_reset();
      test_ignored_start();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
